bch_encode_stream: RTL and testbench



---
 rtl/bch_encode_stream.sv | 161 ++++++++++++++++
 tb/tb_bch_encode_stream.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_encode_stream.sv
// Systematic streaming BCH encoder: message words pass through, then PARITY_BITS of m(x)*x^P mod g(x); 1-cycle latency, gapless codeword.
// No backpressure: ce gates every register, ready only in IDLE; optional BCH_ENCODE_ERR_INJECT_EN adds err_in XORed onto data_out.
module bch_encode_stream #(
    parameter int                     DATA_BITS   = 7,
    parameter int                     PARITY_BITS = 8,
    parameter logic [PARITY_BITS-1:0] GEN_POLY    = 8'hD1,
    parameter int                     BITS        = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            ce,
    input  logic [BITS-1:0] data_in,
`ifdef BCH_ENCODE_ERR_INJECT_EN
    input  logic [BITS-1:0] err_in,
`endif
    output logic            ready,
    output logic [BITS-1:0] data_out,
    output logic            valid,
    output logic            first,
    output logic            last,
    output logic            msg
);

    localparam int D_WORDS   = DATA_BITS / BITS;
    localparam int P_WORDS   = PARITY_BITS / BITS;
    localparam int MAX_WORDS = (D_WORDS > P_WORDS) ? D_WORDS : P_WORDS;
    localparam int CW        = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] D_LAST = CW'(D_WORDS - 1);
    localparam logic [CW-1:0] P_LAST = CW'(P_WORDS - 1);

    generate
        if ((DATA_BITS % BITS) != 0 || (PARITY_BITS % BITS) != 0) begin : g_bad_cfg
            $error("bch_encode_stream: DATA_BITS and PARITY_BITS must be multiples of BITS");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

    state_t                 r_state;
    logic [PARITY_BITS-1:0] r_lfsr;
    logic [CW-1:0]          r_cnt;
    logic [BITS-1:0]        r_data_out;
    logic                   r_valid;
    logic                   r_first;
    logic                   r_last;
    logic                   r_msg;

    logic [PARITY_BITS-1:0] w_seed;
    logic [PARITY_BITS-1:0] w_lfsr_next;
    logic [BITS-1:0]        w_par_word;
    logic [BITS-1:0]        w_msg_out;
    logic [BITS-1:0]        w_par_out;

    // BITS serial division steps per cycle, MSB of the word first.
    function automatic logic [PARITY_BITS-1:0] lfsr_step(input logic [PARITY_BITS-1:0] s_in,
                                                         input logic [BITS-1:0]        w);
        logic [PARITY_BITS-1:0] s;
        logic                   fb;
        s = s_in;
        for (int i = BITS - 1; i >= 0; i--) begin
            fb = w[i] ^ s[PARITY_BITS-1];
            s  = (s << 1) ^ (fb ? GEN_POLY : '0);
        end
        return s;
    endfunction

    // A new codeword must never inherit the previous remainder.
    assign w_seed      = (r_state == S_IDLE) ? '0 : r_lfsr;
    assign w_lfsr_next = lfsr_step(w_seed, data_in);
    assign w_par_word  = r_lfsr[PARITY_BITS-1 -: BITS];

`ifdef BCH_ENCODE_ERR_INJECT_EN
    assign w_msg_out = data_in ^ err_in;
    assign w_par_out = w_par_word ^ err_in;
`else
    assign w_msg_out = data_in;
    assign w_par_out = w_par_word;
`endif

    // The final parity word sits on data_out while already back in IDLE,
    // which is what lets a new start follow it without a bubble.
    assign ready    = (r_state == S_IDLE);
    assign data_out = r_data_out;
    assign valid    = r_valid;
    assign first    = r_first;
    assign last     = r_last;
    assign msg      = r_msg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_lfsr     <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_msg      <= 1'b0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lfsr     <= w_lfsr_next;
                        r_data_out <= w_msg_out;
                        r_valid    <= 1'b1;
                        r_first    <= 1'b1;
                        r_last     <= 1'b0;
                        r_msg      <= 1'b1;
                        if (D_WORDS == 1) begin
                            r_state <= S_PARITY;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_DATA;
                            r_cnt   <= CW'(1);
                        end
                    end else begin
                        r_data_out <= '0;
                        r_valid    <= 1'b0;
                        r_first    <= 1'b0;
                        r_last     <= 1'b0;
                        r_msg      <= 1'b0;
                    end
                end
                S_DATA: begin
                    r_lfsr     <= w_lfsr_next;
                    r_data_out <= w_msg_out;
                    r_valid    <= 1'b1;
                    r_first    <= 1'b0;
                    r_last     <= 1'b0;
                    r_msg      <= 1'b1;
                    if (r_cnt == D_LAST) begin
                        r_state <= S_PARITY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    r_lfsr     <= r_lfsr << BITS;
                    r_data_out <= w_par_out;
                    r_valid    <= 1'b1;
                    r_first    <= 1'b0;
                    r_last     <= (r_cnt == P_LAST);
                    r_msg      <= 1'b0;
                    if (r_cnt == P_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bch_encode_stream.sv
// Bench for bch_encode_stream: default BCH(15,7) instance plus a DATA_BITS=6, BITS=2 instance.
`timescale 1ns/1ps
module tb_bch_encode_stream;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, start2, ce;
    logic [0:0] data_in, data_out;
    logic [1:0] data_in2, data_out2;
    logic       ready, valid, first, last, msg;
    logic       ready2, valid2, first2, last2, msg2;
`ifdef BCH_ENCODE_ERR_INJECT_EN
    logic [0:0] err_in  = '0;
    logic [1:0] err_in2 = '0;
`endif

    bch_encode_stream u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ce(ce), .data_in(data_in),
`ifdef BCH_ENCODE_ERR_INJECT_EN
        .err_in(err_in),
`endif
        .ready(ready), .data_out(data_out), .valid(valid), .first(first), .last(last), .msg(msg)
    );

    bch_encode_stream #(.DATA_BITS(6), .BITS(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .ce(ce), .data_in(data_in2),
`ifdef BCH_ENCODE_ERR_INJECT_EN
        .err_in(err_in2),
`endif
        .ready(ready2), .data_out(data_out2), .valid(valid2), .first(first2), .last(last2), .msg(msg2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] dat;
        logic       first;
        logic       last;
        logic       msgf;
    } ent_t;

    ent_t        q1[$], q2[$];
    ent_t        e1, e2;
    logic        e1_vld, e2_vld;
    logic [15:0] cur_msg1, cur_msg2, f1_msg, f2_msg;
    int          f1_idx, f2_idx;

    localparam logic [8:0] G_FULL = 9'h1D1;

    // Polynomial long division of m(x)*x^8 by g(x).
    function automatic logic [7:0] ref_parity(input logic [15:0] m, input int k);
        logic [31:0] r;
        r = {16'd0, m} << 8;
        for (int i = k + 7; i >= 8; i--)
            if (r[i]) r = r ^ ({23'd0, G_FULL} << (i - 8));
        return r[7:0];
    endfunction

    function automatic logic [1:0] msg_word(input logic [15:0] m, input int k, input int bits, input int j);
        logic [15:0] t;
        t = m >> (k - bits * (j + 1));
        return (bits == 1) ? {1'b0, t[0]} : t[1:0];
    endfunction

    function automatic void push_cw(input int inst, input logic [15:0] m);
        int          k, bits, n, nw;
        logic [31:0] cw, t;
        ent_t        e;
        k    = (inst == 1) ? 6 : 7;
        bits = (inst == 1) ? 2 : 1;
        n    = k + 8;
        nw   = n / bits;
        cw   = ({16'd0, m} << 8) | {24'd0, ref_parity(m, k)};
        for (int w = 0; w < nw; w++) begin
            t       = cw >> (n - bits * (w + 1));
            e.dat   = (bits == 1) ? {1'b0, t[0]} : t[1:0];
            e.first = (w == 0);
            e.last  = (w == nw - 1);
            e.msgf  = (w < k / bits);
            if (inst == 1) q2.push_back(e);
            else           q1.push_back(e);
        end
    endfunction

    // Reference: a codeword is queued when start meets an empty queue; each ce edge emits one word.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1.delete(); e1 = '0; e1_vld = 1'b0; f1_idx = 0;
        end else if (ce) begin
            if (start && q1.size() == 0) begin
                push_cw(0, cur_msg1); f1_msg = cur_msg1; f1_idx = 1;
            end else if (f1_idx != 0) begin
                f1_idx = (f1_idx + 1 == 7) ? 0 : f1_idx + 1;
            end
            if (q1.size() > 0) begin e1 = q1.pop_front(); e1_vld = 1'b1; end
            else               begin e1_vld = 1'b0; end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q2.delete(); e2 = '0; e2_vld = 1'b0; f2_idx = 0;
        end else if (ce) begin
            if (start2 && q2.size() == 0) begin
                push_cw(1, cur_msg2); f2_msg = cur_msg2; f2_idx = 1;
            end else if (f2_idx != 0) begin
                f2_idx = (f2_idx + 1 == 3) ? 0 : f2_idx + 1;
            end
            if (q2.size() > 0) begin e2 = q2.pop_front(); e2_vld = 1'b1; end
            else               begin e2_vld = 1'b0; end
        end
    end

    function automatic logic [5:0] exp1();
        return {e1_vld, 1'(q1.size() == 0), e1.dat[0], e1.first, e1.last, e1.msgf};
    endfunction

    function automatic logic [6:0] exp2();
        return {e2_vld, 1'(q2.size() == 0), e2.dat, e2.first, e2.last, e2.msgf};
    endfunction

    // Drive one cycle of inputs (junk whenever the DUT must ignore data_in), then wait for the next negedge.
    task automatic tick(input logic s1, input logic s2, input logic c);
        logic [1:0] w;
        start = s1; start2 = s2; ce = c;
        if (c && s1 && q1.size() == 0) w = msg_word(cur_msg1, 7, 1, 0);
        else if (c && f1_idx != 0)     w = msg_word(f1_msg, 7, 1, f1_idx);
        else                           w = 2'($urandom);
        data_in = w[0:0];
        if (c && s2 && q2.size() == 0) w = msg_word(cur_msg2, 6, 2, 0);
        else if (c && f2_idx != 0)     w = msg_word(f2_msg, 6, 2, f2_idx);
        else                           w = 2'($urandom);
        data_in2 = w;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; start2 = 1'b0; ce = 1'b0; data_in = '0; data_in2 = '0;
        cur_msg1 = '0; cur_msg2 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid, first, last, msg, data_out} !== 5'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL reset_held got vflmd=%b ready=%b exp 00000 1", {valid, first, last, msg, data_out}, ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, first, last, msg, data_out} !== 5'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL reset_release got vflmd=%b ready=%b exp 00000 1", {valid, first, last, msg, data_out}, ready);
        end
        checks++;
        if ({valid2, first2, last2, msg2, data_out2} !== 6'b0 || ready2 !== 1'b1) begin
            errors++; $display("FAIL reset_wide got vflmd=%b ready=%b exp 000000 1", {valid2, first2, last2, msg2, data_out2}, ready2);
        end
    endtask

    task automatic test_single();
        logic [14:0] bits_got = '0;
        logic [16:0] rmask = '0;
        int          first_at = -1, last_at = -1, nmsg = 0;
        cur_msg1 = 16'h0001;
        tick(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if ({valid, ready} !== exp1()[5:4] || (e1_vld && {valid, ready, data_out, first, last, msg} !== exp1())) begin
                errors++; $display("FAIL single_stream cyc%0d got vrdflm=%b exp %b", c, {valid, ready, data_out, first, last, msg}, exp1());
            end
            if (valid) bits_got = {bits_got[13:0], data_out[0]};
            if (first) first_at = c;
            if (last)  last_at = c;
            if (msg)   nmsg++;
            rmask[c] = ~ready;
            tick(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (bits_got !== 15'b000000111010001) begin
            errors++; $display("FAIL single_codeword got %b exp 000000111010001", bits_got);
        end
        checks++;
        if (first_at != 1 || last_at != 15 || nmsg != 7) begin
            errors++; $display("FAIL single_flags got first@%0d last@%0d msg=%0d exp 1 15 7", first_at, last_at, nmsg);
        end
        checks++;
        if (rmask !== 17'h07FFE) begin
            errors++; $display("FAIL single_ready_low got %h exp 07ffe", rmask);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] par, want;
        for (int p = 0; p < 5; p++) begin
            par = '0;
            cur_msg1 = (p == 0) ? 16'h0000 : (p == 1) ? 16'h007F : 16'($urandom_range(0, 127));
            want = (p == 0) ? 8'h00 : (p == 1) ? 8'hFF : ref_parity(cur_msg1, 7);
            tick(1'b1, 1'b0, 1'b1);
            for (int c = 1; c <= 16; c++) begin
                checks++;
                if ({valid, ready} !== exp1()[5:4] || (e1_vld && {valid, ready, data_out, first, last, msg} !== exp1())) begin
                    errors++; $display("FAIL pattern_stream msg=%h cyc%0d got %b exp %b", cur_msg1, c, {valid, ready, data_out, first, last, msg}, exp1());
                end
                if (valid && !msg) par = {par[6:0], data_out[0]};
                tick(1'b0, 1'b0, 1'b1);
            end
            checks++;
            if (par !== want) begin
                errors++; $display("FAIL pattern_parity msg=%h got %h exp %h", cur_msg1, par, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [29:0] bits_got = '0;
        int          nvld = 0;
        cur_msg1 = 16'h0001;
        tick(1'b1, 1'b0, 1'b1);
        cur_msg1 = 16'h007F;
        for (int c = 1; c <= 31; c++) begin
            checks++;
            if ({valid, ready} !== exp1()[5:4] || (e1_vld && {valid, ready, data_out, first, last, msg} !== exp1())) begin
                errors++; $display("FAIL b2b_stream cyc%0d got %b exp %b", c, {valid, ready, data_out, first, last, msg}, exp1());
            end
            if (c <= 30 && valid) begin
                bits_got = {bits_got[28:0], data_out[0]};
                nvld++;
            end
            tick((c == 12 || c == 15), 1'b0, 1'b1);
        end
        checks++;
        if (nvld != 30 || bits_got !== {15'b000000111010001, 15'h7FFF}) begin
            errors++; $display("FAIL b2b_codewords got n=%0d %b exp 30 %b", nvld, bits_got, {15'b000000111010001, 15'h7FFF});
        end
    endtask

    task automatic test_ce_reset();
        int         nbits = 0;
        logic       last_ce = 1'b1;
        logic [7:0] par = '0;
        logic       c;
        cur_msg1 = 16'($urandom_range(0, 127));
        tick(1'b1, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 60 && nbits < 10; cyc++) begin
            checks++;
            if ({valid, ready} !== exp1()[5:4] || (e1_vld && {valid, ready, data_out, first, last, msg} !== exp1())) begin
                errors++; $display("FAIL ce_stream cyc%0d got %b exp %b", cyc, {valid, ready, data_out, first, last, msg}, exp1());
            end
            if (last_ce && valid) nbits++;
            if (nbits < 10) begin
                c = 1'($urandom_range(0, 1));
                last_ce = c;
                tick(1'b0, 1'b0, c);
            end
        end
        checks++;
        if (nbits != 10) begin
            errors++; $display("FAIL ce_timeout got %0d bits exp 10", nbits);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({valid, first, last, msg, data_out} !== 5'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL midreset_clear got vflmd=%b ready=%b exp 00000 1", {valid, first, last, msg, data_out}, ready);
        end
        reset_n = 1'b1;
        cur_msg1 = 16'h0001;
        tick(1'b1, 1'b0, 1'b1);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            checks++;
            if ({valid, ready} !== exp1()[5:4] || (e1_vld && {valid, ready, data_out, first, last, msg} !== exp1())) begin
                errors++; $display("FAIL post_reset_stream cyc%0d got %b exp %b", cyc, {valid, ready, data_out, first, last, msg}, exp1());
            end
            if (valid && !msg) par = {par[6:0], data_out[0]};
            tick(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (par !== 8'hD1) begin
            errors++; $display("FAIL post_reset_parity got %h exp d1", par);
        end
    endtask

    task automatic test_wide();
        logic [13:0] words;
        int          nvld;
        for (int p = 0; p < 4; p++) begin
            words = '0;
            nvld  = 0;
            cur_msg2 = (p == 0) ? 16'h0001 : 16'($urandom_range(0, 63));
            tick(1'b0, 1'b1, 1'b1);
            for (int c = 1; c <= 8; c++) begin
                checks++;
                if ({valid2, ready2} !== exp2()[6:5] || (e2_vld && {valid2, ready2, data_out2, first2, last2, msg2} !== exp2())) begin
                    errors++; $display("FAIL wide_stream msg=%h cyc%0d got %b exp %b", cur_msg2, c, {valid2, ready2, data_out2, first2, last2, msg2}, exp2());
                end
                if (valid2) begin
                    words = {words[11:0], data_out2};
                    nvld++;
                end
                tick(1'b0, 1'b0, 1'b1);
            end
            if (p == 0) begin
                checks++;
                if (nvld != 7 || words !== 14'b00_00_01_11_01_00_01) begin
                    errors++; $display("FAIL wide_codeword got n=%0d %b exp 7 00000111010001", nvld, words);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_back_to_back();
        test_ce_reset();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
